// File: rtl/keypad_emulator.sv
// keypad_emulator: presents a 3x4 matrix keypad to a column-scanning controller, pressing one
// key per accepted command. Define KEYPAD_EMU_BOUNCE_EN to add contact bounce on press/release.
module keypad_emulator #(
  parameter int CLK_PER_MS     = 50000,
  parameter int GAP_MS         = 20,
  parameter int BOUNCE_PERIOD  = 5000,
  parameter int BOUNCE_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold_ms,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if ((CLK_PER_MS < 1) || (GAP_MS < 1) || (BOUNCE_PERIOD < 1) || (BOUNCE_TOGGLES < 2) ||
      ((BOUNCE_TOGGLES % 2) != 0)) begin : g_bad_cfg
    $error("keypad_emulator: invalid timing parameters");
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int CNT_MAX = (CLK_PER_MS > BOUNCE_PERIOD) ? CLK_PER_MS : BOUNCE_PERIOD;
  localparam int TG_W    = $clog2(BOUNCE_TOGGLES + 1);
`else
  localparam int CNT_MAX = CLK_PER_MS;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int MS_W  = ($clog2(GAP_MS + 1) > 8) ? $clog2(GAP_MS + 1) : 8;
  localparam logic [CNT_W-1:0] MS_LAST  = CNT_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]  GAP_LAST = MS_W'(GAP_MS - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [TG_W-1:0]  TG_LAST = TG_W'(BOUNCE_TOGGLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, PRESS_BOUNCE, HOLD, REL_BOUNCE, GAP} state_t;

  // {active-low row lines, active-low column strobe} for each key; unused codes match nothing
  function automatic logic [6:0] key_lines(input logic [3:0] key);
    case (key)
      4'd1:    key_lines = {4'b1110, 3'b110};
      4'd2:    key_lines = {4'b1110, 3'b101};
      4'd3:    key_lines = {4'b1110, 3'b011};
      4'd4:    key_lines = {4'b1101, 3'b110};
      4'd5:    key_lines = {4'b1101, 3'b101};
      4'd6:    key_lines = {4'b1101, 3'b011};
      4'd7:    key_lines = {4'b1011, 3'b110};
      4'd8:    key_lines = {4'b1011, 3'b101};
      4'd9:    key_lines = {4'b1011, 3'b011};
      4'd10:   key_lines = {4'b0111, 3'b110};
      4'd0:    key_lines = {4'b0111, 3'b101};
      4'd11:   key_lines = {4'b0111, 3'b011};
      default: key_lines = {4'b1111, 3'b111};
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [MS_W-1:0]  ms_r, ms_s, hold_last_s;
  logic             contact_r, contact_s;
  logic             cmd_ready_r, busy_r, done_r, err_r, done_s, err_s;
  logic [3:0]       row_r, row_pat_r;
  logic [2:0]       col_pat_r;
  logic [7:0]       hold_m1_r;
  logic             take_s, accept_s;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [TG_W-1:0]  tgl_r, tgl_s;
`endif

  assign take_s      = cmd_valid && cmd_ready_r;
  assign accept_s    = take_s && (cmd_key <= 4'd11);
  assign hold_last_s = MS_W'(hold_m1_r);

  // Sequencer: phase timing and contact level for the press currently in progress.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + 1'b1;
    ms_s      = ms_r;
    contact_s = contact_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    tgl_s     = tgl_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s     = '0;
        ms_s      = '0;
        contact_s = 1'b0;
        if (accept_s) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_s = PRESS_BOUNCE;
`else
          state_s = HOLD;
`endif
          contact_s = 1'b1;
        end else begin
          err_s = take_s;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      PRESS_BOUNCE: begin
        if (cnt_r == PH_LAST) begin
          cnt_s     = '0;
          contact_s = ~contact_r;
          if (tgl_r == TG_LAST) begin
            tgl_s   = '0;
            state_s = HOLD;
          end else begin
            tgl_s = tgl_r + 1'b1;
          end
        end else begin
          contact_s = contact_r;
        end
      end
`endif
      HOLD: begin
        if (cnt_r == MS_LAST) begin
          cnt_s = '0;
          if (ms_r == hold_last_s) begin
            ms_s      = '0;
            contact_s = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            state_s   = REL_BOUNCE;
`else
            state_s   = GAP;
`endif
          end else begin
            ms_s = ms_r + 1'b1;
          end
        end else begin
          ms_s = ms_r;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      REL_BOUNCE: begin
        if (cnt_r == PH_LAST) begin
          cnt_s     = '0;
          contact_s = ~contact_r;
          if (tgl_r == TG_LAST) begin
            tgl_s   = '0;
            state_s = GAP;
          end else begin
            tgl_s = tgl_r + 1'b1;
          end
        end else begin
          contact_s = contact_r;
        end
      end
`endif
      GAP: begin
        if (cnt_r == MS_LAST) begin
          cnt_s = '0;
          if (ms_r == GAP_LAST) begin
            ms_s    = '0;
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            ms_s = ms_r + 1'b1;
          end
        end else begin
          ms_s = ms_r;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = '0;
        ms_s      = '0;
        contact_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      ms_r        <= '0;
      contact_r   <= 1'b0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tgl_r       <= '0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ms_r        <= ms_s;
      contact_r   <= contact_s;
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      err_r       <= err_s;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tgl_r       <= tgl_s;
`endif
    end
  end

  // Capture the accepted key's matrix lines and hold time (0 ms behaves as 1 ms).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_pat_r <= 4'b1111;
      col_pat_r <= 3'b111;
      hold_m1_r <= 8'd0;
    end else if (accept_s) begin
      {row_pat_r, col_pat_r} <= key_lines(cmd_key);
      hold_m1_r <= (cmd_hold_ms == 8'd0) ? 8'd0 : (cmd_hold_ms - 8'd1);
    end
  end

  // Row lines answer the strobe one clock later; an invalid strobe never equals the latched column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= 4'b1111;
    end else begin
      row_r <= (contact_r && (col == col_pat_r)) ? row_pat_r : 4'b1111;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign row       = row_r;

endmodule
